// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / MEM-stage RAM port arbiter.
// Holds the bus widths, the FSM state encoding, the access-size codes, the
// owner codes and the default I/O base address. Optional build macro used by
// the arbiter: MEM_ARB_FAIR_EN.
package mem_arbiter_pkg;

  // Bus widths
  localparam int BUS_W  = 32;
  localparam int BYTE_W = 8;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_TAIL  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // MEM access size codes
  localparam logic [1:0] CNF_NONE = 2'd0;
  localparam logic [1:0] CNF_B    = 2'd1;
  localparam logic [1:0] CNF_H    = 2'd2;
  localparam logic [1:0] CNF_W    = 2'd3;

  // Transaction owner codes
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // Start of the memory-mapped I/O region
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Number of RAM byte cycles for a MEM access size
  function automatic logic [2:0] cnf_to_n(input logic [1:0] cnf);
    logic [2:0] n;
    case (cnf)
      CNF_B:   n = 3'd1;
      CNF_H:   n = 3'd2;
      CNF_W:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_seq.sv
// mem_byte_seq: byte sequencer behind the arbiter FSM. Latches the transfer
// parameters on start, steps the RAM byte address once per issue cycle,
// selects the little-endian write byte and assembles read bytes that arrive
// one cycle after their address.
module mem_byte_seq
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [2:0]        i_n,
  input  logic              i_wr,
  input  logic [BUS_W-1:0]  i_wdata,
  input  logic [BYTE_W-1:0] i_ram_din,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic [BYTE_W-1:0] o_ram_dout,
  output logic              o_last,
  output logic              o_done,
  output logic [BUS_W-1:0]  o_rdata
);

  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_cnt;
  logic [2:0]        r_n;
  logic              r_wr;
  logic [BUS_W-1:0]  r_wdata;
  logic [BUS_W-1:0]  r_asm;
  logic              r_cap_en;
  logic [1:0]        r_cap_idx;

  logic [BYTE_W-1:0] w_wbyte [4];
  logic [BUS_W-1:0]  w_asm_next;

  // Per-byte write select and read merge (byte gi lands in bits [8gi+7:8gi])
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign w_wbyte[gi] = r_wdata[BYTE_W*gi +: BYTE_W];
      assign w_asm_next[BYTE_W*gi +: BYTE_W] =
        (r_cap_en && (r_cap_idx == 2'(gi))) ? i_ram_din : r_asm[BYTE_W*gi +: BYTE_W];
    end
  endgenerate

  assign o_ram_a    = r_addr;
  assign o_ram_dout = w_wbyte[r_cnt[1:0]];
  assign o_last     = (r_cnt == (r_n - 3'd1));
  assign o_done     = r_cap_en && ({1'b0, r_cap_idx} == (r_n - 3'd1));
  assign o_rdata    = w_asm_next;

  // Latch transfer on start, then advance address/count and capture read bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_cnt     <= 3'd0;
      r_n       <= 3'd0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_asm     <= '0;
      r_cap_en  <= 1'b0;
      r_cap_idx <= 2'd0;
    end else if (i_start) begin
      r_addr    <= i_base;
      r_cnt     <= 3'd0;
      r_n       <= i_n;
      r_wr      <= i_wr;
      r_wdata   <= i_wdata;
      r_asm     <= '0;
      r_cap_en  <= 1'b0;
      r_cap_idx <= 2'd0;
    end else begin
      r_asm    <= w_asm_next;
      // Byte issued this cycle is on ram_din next cycle
      r_cap_en <= i_step && !r_wr;
      if (i_step) begin
        r_cap_idx <= r_cnt[1:0];
        r_cnt     <= r_cnt + 3'd1;
        // Hold the last issued address so ram_a is stable while idle
        if (!o_last) begin
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between instruction fetch and
// the MEM stage. One requester is granted at a time and its B/H/W access is
// serialised into little-endian byte cycles by mem_byte_seq.
// Optional build macro: MEM_ARB_FAIR_EN (alternate to IF after a MEM grant).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int              ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_done,
  output logic [BUS_W-1:0]  o_if_data,
  input  logic              i_mem_req,
  input  logic              i_mem_wr,
  input  logic [1:0]        i_mem_cnf,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [BUS_W-1:0]  i_mem_wdata,
  output logic              o_mem_done,
  output logic [BUS_W-1:0]  o_mem_rdata,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic              o_ram_wr,
  output logic [BYTE_W-1:0] o_ram_dout,
  input  logic [BYTE_W-1:0] i_ram_din
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             r_owner;
  logic             r_wr;
  logic [BUS_W-1:0] r_if_data;
  logic [BUS_W-1:0] r_mem_rdata;

  logic             w_mem_valid;
  logic             w_if_valid;
  logic             w_grant_mem;
  logic             w_grant_if;
  logic             w_start;
  logic             w_step;
  logic             w_flush_own;
  logic             w_if_done;
  logic             w_mem_done;
  logic [ADDR_W-1:0] w_seq_base;
  logic [2:0]       w_seq_n;
  logic             w_seq_last;
  logic             w_seq_done;
  logic [BUS_W-1:0] w_seq_rdata;

  assign w_mem_valid = i_mem_req && (i_mem_cnf != CNF_NONE);
  assign w_if_valid  = i_if_req && !i_if_flush;

`ifdef MEM_ARB_FAIR_EN
  logic r_last_owner;

  // After a completed MEM grant, IF wins a tie
  assign w_grant_if  = w_if_valid && (!w_mem_valid || (r_last_owner == OWN_MEM));
  assign w_grant_mem = w_mem_valid && !w_grant_if;

  // Remember who completed last
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= OWN_IF;
    end else if (w_if_done || w_mem_done) begin
      r_last_owner <= r_owner;
    end
  end
`else
  assign w_grant_mem = w_mem_valid;
  assign w_grant_if  = w_if_valid && !w_mem_valid;
`endif

  assign w_start     = (r_state == ST_IDLE) && (w_grant_mem || w_grant_if);
  assign w_step      = (r_state == ST_ISSUE);
  assign w_flush_own = i_if_flush && (r_owner == OWN_IF);
  assign w_seq_base  = w_grant_mem ? i_mem_addr : i_if_addr;
  assign w_seq_n     = w_grant_mem ? cnf_to_n(i_mem_cnf) : 3'd4;

  // A flush arriving in the IF response cycle still cancels the done pulse
  assign w_if_done  = (r_state == ST_RESP) && (r_owner == OWN_IF) && !i_if_flush;
  assign w_mem_done = (r_state == ST_RESP) && (r_owner == OWN_MEM);

  mem_byte_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_step     (w_step),
    .i_base     (w_seq_base),
    .i_n        (w_seq_n),
    .i_wr       (w_grant_mem && i_mem_wr),
    .i_wdata    (i_mem_wdata),
    .i_ram_din  (i_ram_din),
    .o_ram_a    (o_ram_a),
    .o_ram_dout (o_ram_dout),
    .o_last     (w_seq_last),
    .o_done     (w_seq_done),
    .o_rdata    (w_seq_rdata)
  );

  // Next-state logic: IDLE -> ISSUE -> (TAIL for reads) -> RESP -> IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_flush_own)     w_state_next = ST_IDLE;
        else if (w_seq_last) w_state_next = r_wr ? ST_RESP : ST_TAIL;
      end
      ST_TAIL: begin
        if (w_flush_own)     w_state_next = ST_IDLE;
        else if (w_seq_done) w_state_next = ST_RESP;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, owner and direction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_IF;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_owner <= w_grant_mem ? OWN_MEM : OWN_IF;
        r_wr    <= w_grant_mem && i_mem_wr;
      end
    end
  end

  // Returned data holds until the next done for the same port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (w_if_done)           r_if_data   <= w_seq_rdata;
      if (w_mem_done && !r_wr) r_mem_rdata <= w_seq_rdata;
    end
  end

  assign o_if_done   = w_if_done;
  assign o_mem_done  = w_mem_done;
  assign o_if_data   = w_if_done ? w_seq_rdata : r_if_data;
  assign o_mem_rdata = (w_mem_done && !r_wr) ? w_seq_rdata : r_mem_rdata;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_ram_wr    = (r_state == ST_ISSUE) && r_wr;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
- Grants one requester at a time.
- Serialises B/H/W accesses into 1/2/4 byte cycles, little-endian.
- Returns assembled read data with a one-cycle done pulse.
- Sits between the IF/MEM stages and the RAM, and is the only driver of the RAM pins.

Parameters:
ADDR_W, 32, width of byte address to RAM and requesters
IO_BASE, 32'h30000, lowest address of I/O region (used only by optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  IF wants a 32-bit instruction word; held until if_done or flush
if_addr  in  ADDR_W  IF word address; stable while if_req
if_flush  in  1  cancel pending/in-flight IF fetch
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
mem_req  in  1  MEM access request; held with fields stable until mem_done
mem_wr  in  1  0 load, 1 store
mem_cnf  in  2  1=B, 2=H, 3=W; 0=no access
mem_addr  in  ADDR_W  byte address
mem_wdata  in  32  store data, low bytes used
mem_done  out  1  one-cycle pulse; mem_rdata valid for loads
mem_rdata  out  32  load data, zero-extended; MEM stage sign-extends
busy  out  1  transaction in flight (state != IDLE)
ram_a  out  ADDR_W  RAM byte address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte, valid one cycle after ram_a

Behaviour:
- Reset (synchronous, active-high): state IDLE, all outputs 0, byte counter 0, assembly register 0. Reset mid-transaction aborts immediately; no done pulse is issued.
- Requests are sampled only in IDLE.
  - mem_req with mem_cnf=0 is ignored.
  - Arbitration is fixed priority: MEM over IF.
  - Grant latches addr, wr, byte count n (B=1, H=2, W=4, IF=4), wdata and owner.
- States:
  - IDLE: on grant go to ISSUE.
  - ISSUE: lasts n cycles. In cycle i: ram_a = base+i (wraps mod 2^ADDR_W); ram_wr = wr; ram_dout = wdata[8i+7:8i].
  - Reads: the byte issued in ISSUE cycle i is captured from ram_din the next cycle into bits [8i+7:8i].
  - After the last issue cycle, reads go to TAIL (capture last byte); writes go to RESP.
  - TAIL: capture only; go to RESP.
  - RESP: drive the owner's done pulse and data (registered); go to IDLE.
- Latency from the grant cycle to the done pulse: read n+2 cycles, write n+1 cycles. Max IF throughput is one word per 7 cycles.
- ram_wr is 0 in every cycle outside ISSUE and during reads. ram_a holds its last value when idle.
- if_flush:
  - In IDLE: suppresses an IF grant that cycle.
  - During an IF-owned ISSUE/TAIL/RESP: next state IDLE, no if_done; RAM reads have no side effects.
  - No effect on MEM-owned transactions. Stores are never aborted.
- if_done and mem_done are never asserted in the same cycle. Data outputs hold their value until the next done for the same port.
- The done cycle returns to IDLE. The requester must deassert req in the cycle after done, or it is re-granted.

Optional Feature:
MEM_ARB_FAIR_EN
- Defined: a 1-bit last_owner register is added. When both request in IDLE and the last completed grant was MEM, IF wins; otherwise MEM wins. This prevents IF starvation under a store-heavy stream.
- Undefined: fixed MEM priority as above, and no last_owner register exists.

Decomposition:
- Shared package/defines: state encoding (IDLE, ISSUE, TAIL, RESP), mem_cnf codes (CNF_NONE/B/H/W), owner codes (OWN_IF/OWN_MEM), and IO_BASE default, added alongside the existing bus-width defines.
- One natural sub-module, mem_byte_seq: holds the byte counter, address increment, write-byte select and read assembly. It is driven by the arbiter FSM via start/n/wr and reports last/done.

Test Plan:
- IF fetch: RAM[0x100..0x103]=13,00,50,00; if_req, addr 0x100 → ram_a 0x100..0x103 in 4 consecutive cycles; if_done 6 cycles after grant; if_data=0x00500013.
- MEM store H: cnf=2, wr=1, addr 0x204, wdata 0xDEADBEEF → ram_wr=1 on exactly 2 cycles, bytes EF then BE at 0x204/0x205; mem_done 3 cycles after grant; RAM[0x206] unchanged.
- Contention: if_req and mem_req (load B, 0x10, RAM=0x80) asserted together → MEM granted first, mem_rdata=0x00000080; IF granted in the IDLE cycle after mem_done. With MEM_ARB_FAIR_EN and a prior MEM grant, IF is granted first.
- Flush: if_flush asserted 2 cycles into an IF fetch → busy falls next cycle, no if_done. A new if_req at 0x40 then completes normally with correct data.
- Reset mid-store: rst during ISSUE cycle 1 of a W store → next cycle all outputs 0, ram_wr=0, state IDLE, no mem_done.
- Wrap: load W at address 2^ADDR_W−2 → ram_a sequence FF..FE, FF..FF, 0, 1; data assembled in byte order.
